// File: rtl/seed_lfsr_source.sv
// Seed feeder: fills the generator seed FIFO with one frame of Q8.8 words from a Galois LFSR.
// Define SEED_LFSR_CLT_EN to average four samples per word (approximately Gaussian output).
module seed_lfsr_source #(
    parameter int unsigned SEED_COUNT = 64,
    parameter logic [31:0] LFSR_INIT  = 32'hACE1_2468,
    parameter logic [31:0] LFSR_MASK  = 32'h8020_0003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        seed_load,
    input  logic [31:0] seed_value,
    input  logic        seed_full,
    output logic        seed_wr_en,
    output logic [15:0] seed_wr_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned   CntW    = (SEED_COUNT > 1) ? $clog2(SEED_COUNT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(SEED_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StGen, StFin} state_e;

    state_e            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d, lfsr_adv;
    logic [CntW-1:0]   word_cnt_q, word_cnt_d;
    logic              sample_valid_q, sample_valid_d;
    logic [15:0]       sample_q, sample_d;
    logic              wr_accept, last_word, gen_step;

`ifdef SEED_LFSR_CLT_EN
    logic [10:0]       acc_q, acc_d, acc_sum, acc_avg;
    logic [1:0]        phase_q, phase_d;
`endif

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        logic [31:0] n;
        n = r >> 1;
        if (r[0]) begin
            n = n ^ LFSR_MASK;
        end
        return n;
    endfunction

    assign lfsr_adv  = lfsr_step(lfsr_q);
    assign wr_accept = sample_valid_q & ~seed_full;
    assign last_word = wr_accept && (word_cnt_q == LastCnt);
    // A fresh sample is built when none is pending, or right behind an accepted non-final write.
    assign gen_step  = (state_q == StGen) && (!sample_valid_q || (wr_accept && !last_word));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && !seed_load) state_d = StGen;
            StGen:  if (last_word)           state_d = StFin;
            StFin:                           state_d = StIdle;
            default:                         state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        seed_wr_en   = wr_accept;
        seed_wr_data = sample_q;
        busy         = (state_q == StGen);
        done         = (state_q == StFin);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q         <= LFSR_INIT;
            word_cnt_q     <= '0;
            sample_valid_q <= 1'b0;
            sample_q       <= '0;
`ifdef SEED_LFSR_CLT_EN
            acc_q          <= '0;
            phase_q        <= '0;
`endif
        end else begin
            lfsr_q         <= lfsr_d;
            word_cnt_q     <= word_cnt_d;
            sample_valid_q <= sample_valid_d;
            sample_q       <= sample_d;
`ifdef SEED_LFSR_CLT_EN
            acc_q          <= acc_d;
            phase_q        <= phase_d;
`endif
        end
    end

    // Datapath next-state
    always_comb begin
        lfsr_d         = lfsr_q;
        word_cnt_d     = word_cnt_q;
        sample_valid_d = sample_valid_q;
        sample_d       = sample_q;
`ifdef SEED_LFSR_CLT_EN
        acc_d          = acc_q;
        phase_d        = phase_q;
        acc_sum        = acc_q + {{2{lfsr_adv[8]}}, lfsr_adv[8:0]};
        acc_avg        = $signed(acc_sum) >>> 2;
`endif

        if (state_q == StIdle) begin
            if (seed_load) begin
                lfsr_d = (seed_value == 32'd0) ? LFSR_INIT : seed_value;
            end else if (start) begin
                word_cnt_d = '0;
            end
        end

        if (wr_accept && !last_word) begin
            word_cnt_d = word_cnt_q + CntW'(1);
        end
        if (last_word) begin
            sample_valid_d = 1'b0;
        end

        if (gen_step) begin
            lfsr_d = lfsr_adv;
`ifdef SEED_LFSR_CLT_EN
            if (phase_q == 2'd3) begin
                sample_d       = {{5{acc_avg[10]}}, acc_avg};
                sample_valid_d = 1'b1;
                acc_d          = '0;
                phase_d        = '0;
            end else begin
                sample_valid_d = 1'b0;
                acc_d          = acc_sum;
                phase_d        = phase_q + 2'd1;
            end
`else
            sample_d       = {{7{lfsr_adv[8]}}, lfsr_adv[8:0]};
            sample_valid_d = 1'b1;
`endif
        end
    end

endmodule
